uart_rx: RTL and testbench

UART receiver: deserialises the asynchronous serial line into bytes and hands them downstream on a valid/ready interface. It is the receive-side counterpart of the UART transmitter and uses the same frame: start bit 0, 8 data bits LSB first, even-parity bit equal to the XOR of the data bits, and stop bit 1. It sits between the board-level `rx` pin and the byte consumer, for example a FIFO or command decoder.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and even-parity helper.
// UART_RX_SYNC_EN selects the two-flop input synchroniser depth used by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

`ifdef UART_RX_SYNC_EN
  localparam int UART_RX_SYNC_STAGES = 2;
`else
  localparam int UART_RX_SYNC_STAGES = 1;
`endif

  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx input stage: two-flop synchroniser with UART_RX_SYNC_EN, single register otherwise.
// Latency 2 or 1 cycles; no backpressure; every flop resets to line-idle (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);

`ifdef UART_RX_SYNC_EN
  logic rx_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_s <= 1'b1;
    else        rx_s <= rx;
  end
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8E1, LSB first) to a valid/ready byte port; valid at E+H+10*CLKS_PER_BIT+1.
// A frame completing while valid && !ready is dropped with a one-cycle overrun pulse. Macro: UART_RX_SYNC_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                      clk,
  input  logic                      ret,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t              state, state_nxt;
  logic                        rx_s, rx_q;
  logic [UART_RX_SYNC_STAGES:0] settle;
  logic                        armed;
  logic [CW-1:0]               cnt;
  logic [2:0]                  bit_cnt;
  logic [UART_DATA_BITS-1:0]   shift_reg;
  logic                        perr_q;
  logic                        tick, start_det, complete, load;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (ret),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  // Starts are only accepted once a genuinely sampled high line has been seen,
  // so a line held low across reset release is not mistaken for a start edge.
  assign start_det = armed && rx_q && (rx_s == UART_START_BIT);
  assign tick      = (cnt == ((state == START) ? HALF_LAST : BIT_LAST));
  assign complete  = (state == STOP) && tick;
  assign load      = complete && (!valid || ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge ret) begin
    if (!ret) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start_det) state_nxt = START;
      START:  if (tick) state_nxt = (rx_s == UART_START_BIT) ? DATA : IDLE;
      DATA:   if (tick && bit_cnt == LAST_BIT) state_nxt = PARITY;
      PARITY: if (tick) state_nxt = STOP;
      STOP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      rx_q      <= 1'b1;
      settle    <= '0;
      armed     <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      perr_q    <= 1'b0;
    end else begin
      rx_q   <= rx_s;
      settle <= {settle[UART_RX_SYNC_STAGES-1:0], 1'b1};
      if (settle[UART_RX_SYNC_STAGES] && rx_q && rx_s) armed <= 1'b1;

      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + CW'(1);

      if (state == IDLE)               bit_cnt <= '0;
      else if (state == DATA && tick)  bit_cnt <= bit_cnt + 3'd1;

      if (state == DATA && tick) shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
      if (state == PARITY && tick) perr_q <= rx_s ^ uart_parity(shift_reg);
    end
  end

  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= complete && valid && !ready;
      if (load) begin
        data       <= shift_reg;
        parity_err <= perr_q;
        frame_err  <= (rx_s != UART_STOP_BIT);
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised bit by bit, expected bytes queued at send
// time and compared when the consumer accepts them.
module tb_uart_rx;

  localparam int CPB = 8;
  localparam int H   = CPB / 2;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       ret = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, overrun, busy;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   ovr_cnt = 0;
  int   rise_cyc = -1;
  logic valid_d = 1'b0;
  exp_t exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .ret        (ret),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Consumer side: compare each accepted byte against the oldest expectation.
  always @(negedge clk) begin
    if (valid && !valid_d) rise_cyc = cyc;
    valid_d = valid;
    if (overrun) ovr_cnt++;
    if (valid && ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_byte", {24'd0, data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data", {24'd0, data}, {24'd0, e.d});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step(1);
    @(negedge clk);
  endtask

  // Drives start, data LSB first, parity and stop; the line is left at the stop value.
  task automatic send(input logic [7:0] d, input logic par, input logic stop, input logic push);
    logic [10:0] bits;
    exp_t        e;
    bits = {stop, par, d, 1'b0};
    if (push) begin
      e.d  = d;
      e.pe = par ^ (^d);
      e.fe = ~stop;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      step(CPB);
    end
  endtask

  initial begin
    int t0, acc0, ovr0;
    logic [10:0] bits;

    step(3);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    ret = 1'b1;
    step(6);

    // Clean frame, latency and single-cycle valid.
    t0 = cyc;
    send(8'hA5, 1'b0, 1'b1, 1'b1);
    step(4);
    chk("clean_latency", rise_cyc, t0 + SYNC_LAT + H + 10 * CPB + 1);
    chk("clean_valid_low", {31'd0, valid}, 32'd0);

    send(8'h01, 1'b0, 1'b1, 1'b1);
    step(4);

    // Stop bit 0, then a long break: exactly one byte.
    acc0 = acc_cnt;
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    step(30 * CPB);
    chk("break_single", acc_cnt, acc0 + 1);
    chk("break_idle", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    step(2 * CPB);
    send(8'h96, 1'b0, 1'b1, 1'b1);
    step(4);

    // Glitch shorter than half a bit.
    acc0 = acc_cnt;
    t0 = cyc;
    rx = 1'b0;
    step(2);
    rx = 1'b1;
    wait_cyc(t0 + SYNC_LAT + 2);
    chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
    wait_cyc(t0 + SYNC_LAT + H + 1);
    chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
    step(3 * CPB);
    chk("glitch_no_valid", acc_cnt, acc0);

    // Backpressure and overrun.
    ready = 1'b0;
    ovr0 = ovr_cnt;
    send(8'h11, 1'b0, 1'b1, 1'b1);
    send(8'h22, 1'b0, 1'b1, 1'b0);
    step(4);
    chk("bp_overrun_once", ovr_cnt, ovr0 + 1);
    chk("bp_valid_held", {31'd0, valid}, 32'd1);
    chk("bp_data_kept", {24'd0, data}, 32'h11);
    ready = 1'b1;
    step(1);
    @(negedge clk);
    chk("bp_valid_fell", {31'd0, valid}, 32'd0);
    step(2);

    // Reset during data bit 4 of 0x5A.
    acc0 = acc_cnt;
    bits = {1'b1, 1'b0, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      step(CPB);
    end
    rx = bits[5];
    step(H);
    ret = 1'b0;
    rx = 1'b1;
    step(3);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    ret = 1'b1;
    step(2 * CPB);
    send(8'hC3, 1'b0, 1'b1, 1'b1);
    step(4);
    chk("midrst_one_byte", acc_cnt, acc0 + 1);

    // Line held low through reset release is not a start.
    acc0 = acc_cnt;
    ret = 1'b0;
    rx = 1'b0;
    step(3);
    ret = 1'b1;
    step(3 * CPB);
    chk("lowrel_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    step(2 * CPB);
    chk("lowrel_no_valid", acc_cnt, acc0);

    begin
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
        step(1);
        guard++;
      end
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
